// File: rtl/pmod_gpio_debounce_if.sv
// Pin-level bundle between the AXI GPIO core, this debounce block and the Pmod remap stage.
// The slave modport is the debounce block's view; master is the surrounding logic.
interface pmod_gpio_debounce_if #(
  parameter int NUM_PINS = 8
);
  logic [NUM_PINS-1:0] s_gpio_tri_t;
  logic [NUM_PINS-1:0] s_gpio_tri_o;
  logic [NUM_PINS-1:0] s_gpio_tri_i;
  logic [NUM_PINS-1:0] m_gpio_tri_t;
  logic [NUM_PINS-1:0] m_gpio_tri_o;
  logic [NUM_PINS-1:0] m_gpio_tri_i;
  logic [NUM_PINS-1:0] rise_en;
  logic [NUM_PINS-1:0] fall_en;
  logic [NUM_PINS-1:0] edge_clear;
  logic [NUM_PINS-1:0] edge_status;
  logic                irq;

  // Plain level signals: no valid/ready handshake. Readback and edge flags are
  // continuously valid; edge_clear is a one-cycle write-1-to-clear pulse.
  modport slave (
    input  s_gpio_tri_t, s_gpio_tri_o, m_gpio_tri_i, rise_en, fall_en, edge_clear,
    output s_gpio_tri_i, m_gpio_tri_t, m_gpio_tri_o, edge_status, irq
  );

  modport master (
    output s_gpio_tri_t, s_gpio_tri_o, m_gpio_tri_i, rise_en, fall_en, edge_clear,
    input  s_gpio_tri_i, m_gpio_tri_t, m_gpio_tri_o, edge_status, irq
  );
endinterface

// File: rtl/pmod_gpio_debounce.sv
// Pmod GPIO pass-through with synchronized, debounced pin readback.
// Optional edge capture / level interrupt enabled by defining PMODGPIO_DEBOUNCE_EDGE_IRQ_EN.
module pmod_gpio_debounce #(
  parameter int NUM_PINS        = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  pmod_gpio_debounce_if.slave        gpio
);
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] sync;
  logic [NUM_PINS-1:0] db;
  logic [CW-1:0]       cnt [NUM_PINS];

  assign gpio.m_gpio_tri_t = gpio.s_gpio_tri_t;
  assign gpio.m_gpio_tri_o = gpio.s_gpio_tri_o;
  assign gpio.s_gpio_tri_i = db;
  assign sync              = sync_q[SYNC_STAGES-1];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpio.m_gpio_tri_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Any cycle where sync agrees with db restarts the count, so glitches leave no trace.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      db <= '0;
      for (int i = 0; i < NUM_PINS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PINS; i++) begin
        if (sync[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= sync[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef PMODGPIO_DEBOUNCE_EDGE_IRQ_EN
  logic [NUM_PINS-1:0] update;
  logic [NUM_PINS-1:0] set_vec;
  logic [NUM_PINS-1:0] status_q;
  logic                irq_q;

  always_comb begin
    update = '0;
    for (int i = 0; i < NUM_PINS; i++) update[i] = (sync[i] != db[i]) && (cnt[i] == CNT_MAX);
    set_vec = update & ((sync & gpio.rise_en) | (~sync & gpio.fall_en));
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= (status_q & ~gpio.edge_clear) | set_vec;
      irq_q    <= |status_q;
    end
  end

  assign gpio.edge_status = status_q;
  assign gpio.irq         = irq_q;
`else
  logic unused_edge_inputs;
  assign unused_edge_inputs = ^{gpio.rise_en, gpio.fall_en, gpio.edge_clear};
  assign gpio.edge_status   = '0;
  assign gpio.irq           = 1'b0;
`endif
endmodule

// File: tb/tb_pmod_gpio_debounce.sv
// Directed bench for pmod_gpio_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Expected readback values are queued when pins are driven and popped when the DUT output moves.
module tb_pmod_gpio_debounce;
`ifdef PMODGPIO_DEBOUNCE_EDGE_IRQ_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif
  localparam int W   = 8;
  localparam int LAT = 6;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;
  logic [W-1:0] exp_q[$];

  pmod_gpio_debounce_if #(.NUM_PINS(W)) bus ();

  pmod_gpio_debounce #(
    .NUM_PINS(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .gpio(bus)
  );

  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  function automatic logic [W-1:0] edge_exp(input logic [W-1:0] v);
    return EDGE_EN ? v : '0;
  endfunction

  // Wait (bounded) for the readback to move, then check value and latency.
  task automatic settle(input string tag, input int exp_lat);
    logic [W-1:0] start;
    logic [W-1:0] exp_val;
    int lat;
    start = bus.s_gpio_tri_i;
    lat = 0;
    while (bus.s_gpio_tri_i === start && lat < 40) begin
      step(1);
      lat++;
    end
    exp_val = (exp_q.size() != 0) ? exp_q.pop_front() : start;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_val"}, bus.s_gpio_tri_i, exp_val);
  endtask

  initial begin
    bus.s_gpio_tri_t = 8'hA5;
    bus.s_gpio_tri_o = 8'h3C;
    bus.m_gpio_tri_i = 8'h00;
    bus.rise_en      = 8'h00;
    bus.fall_en      = 8'h00;
    bus.edge_clear   = 8'h00;

    // Reset values and pass-through during reset
    #2;
    check("rst_tri_t", bus.m_gpio_tri_t, 8'hA5);
    check("rst_tri_o", bus.m_gpio_tri_o, 8'h3C);
    check("rst_tri_i", bus.s_gpio_tri_i, 8'h00);
    check("rst_status", bus.edge_status, 8'h00);
    check("rst_irq", bus.irq, 1'b0);
    #20;
    aresetn = 1'b1;
    step(1);
    check("pt_tri_t", bus.m_gpio_tri_t, 8'hA5);
    check("pt_tri_o", bus.m_gpio_tri_o, 8'h3C);
    bus.s_gpio_tri_t = 8'h5A;
    bus.s_gpio_tri_o = 8'hC3;
    #1;
    check("pt2_tri_t", bus.m_gpio_tri_t, 8'h5A);
    check("pt2_tri_o", bus.m_gpio_tri_o, 8'hC3);
    step(1);

    // Clean rising transition on bit 0
    bus.rise_en = 8'h01;
    bus.m_gpio_tri_i = 8'h01;
    exp_q.push_back(8'h01);
    settle("clean", LAT);
    check("clean_status", bus.edge_status, edge_exp(8'h01));
    check("clean_irq0", bus.irq, 1'b0);
    step(1);
    check("clean_irq1", bus.irq, EDGE_EN);
    bus.edge_clear = 8'h01;
    step(1);
    bus.edge_clear = 8'h00;
    check("clean_clr_status", bus.edge_status, 8'h00);
    step(1);
    check("clean_clr_irq", bus.irq, 1'b0);

    // Glitch on bit 3, three cycles wide
    bus.rise_en = 8'hFF;
    bus.m_gpio_tri_i = 8'h09;
    step(3);
    bus.m_gpio_tri_i = 8'h01;
    step(10);
    check("glitch_tri_i", bus.s_gpio_tri_i, 8'h01);
    check("glitch_status", bus.edge_status, 8'h00);
    check("glitch_irq", bus.irq, 1'b0);

    // Bit 7 settles high without an event, then falls with fall_en
    bus.rise_en = 8'h00;
    bus.m_gpio_tri_i = 8'h81;
    exp_q.push_back(8'h81);
    settle("b7_high", LAT);
    check("b7_high_status", bus.edge_status, 8'h00);
    bus.fall_en = 8'h80;
    bus.m_gpio_tri_i = 8'h01;
    exp_q.push_back(8'h01);
    settle("b7_fall", LAT);
    check("fall_status", bus.edge_status, edge_exp(8'h80));
    step(1);
    check("fall_irq", bus.irq, EDGE_EN);
    bus.edge_clear = 8'h80;
    step(1);
    bus.edge_clear = 8'h00;
    check("fall_clr_status", bus.edge_status, 8'h00);
    check("fall_clr_irq_hold", bus.irq, EDGE_EN);
    step(1);
    check("fall_clr_irq", bus.irq, 1'b0);

    // Set/clear collision on bit 0
    bus.fall_en = 8'h00;
    bus.m_gpio_tri_i = 8'h00;
    exp_q.push_back(8'h00);
    settle("b0_low", LAT);
    check("b0_low_status", bus.edge_status, 8'h00);
    bus.rise_en = 8'h01;
    bus.m_gpio_tri_i = 8'h01;
    step(5);
    check("coll_pre_tri_i", bus.s_gpio_tri_i, 8'h00);
    bus.edge_clear = 8'h01;
    step(1);
    bus.edge_clear = 8'h00;
    check("coll_tri_i", bus.s_gpio_tri_i, 8'h01);
    check("coll_status", bus.edge_status, edge_exp(8'h01));
    step(1);
    check("coll_status_hold", bus.edge_status, edge_exp(8'h01));
    check("coll_irq", bus.irq, EDGE_EN);

    // Reset in the middle of a debounce count
    bus.rise_en = 8'hFF;
    bus.m_gpio_tri_i = 8'hFF;
    step(4);
    aresetn = 1'b0;
    #1;
    check("mid_rst_tri_i", bus.s_gpio_tri_i, 8'h00);
    check("mid_rst_status", bus.edge_status, 8'h00);
    check("mid_rst_irq", bus.irq, 1'b0);
    check("mid_rst_tri_t", bus.m_gpio_tri_t, 8'h5A);
    step(2);
    aresetn = 1'b1;
    exp_q.push_back(8'hFF);
    settle("post_rst", LAT);
    check("post_rst_status", bus.edge_status, edge_exp(8'hFF));
    step(1);
    check("post_rst_irq", bus.irq, EDGE_EN);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
